// File: rtl/divu_arbiter.sv
// Shares one fixed-point divu among NREQ requesters: round-robin grant, one
// division in flight, response demux, and a watchdog for a hung divider.

module divu_arbiter_lane #(
  parameter int IDW = 1,
  parameter int IDX = 0
) (
  input  logic           idle,
  input  logic           found,
  input  logic [IDW-1:0] gsel,
  input  logic           rsp_vld,
  input  logic           rsp_rdy,
  output logic           req_rdy,
  output logic           rsp_hs
);
  assign req_rdy = idle & found & (gsel == IDW'(IDX));
  assign rsp_hs  = rsp_vld & rsp_rdy;
endmodule

module divu_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int FBITS   = 16,
  parameter int TIMEOUT = WIDTH + FBITS + 4,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_val,
  output logic [1:0]            rsp_status,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic                  div_rst,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic                  div_busy,
  input  logic                  div_done,
  input  logic                  div_valid,
  input  logic                  div_dbz,
  input  logic                  div_ovf,
  input  logic [WIDTH-1:0]      div_val
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]                 state;
  logic [IDW-1:0]             ptr;
  logic [CW-1:0]              cnt;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NREQ-1:0]            rsp_hs;
  logic                       hi_hit, lo_hit, found, handshake, wdog;
  logic [IDW-1:0]             hi_idx, lo_idx, gsel;

  // div_busy is informational and div_done alone qualifies a result.
  logic unused_div;
  assign unused_div = div_busy ^ div_valid;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Lowest valid index at/above ptr wins; otherwise wrap to the lowest valid.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
  end

  assign found = lo_hit;
  assign gsel  = hi_hit ? hi_idx : lo_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    divu_arbiter_lane #(.IDW(IDW), .IDX(i)) u_lane (
      .idle    (state == S_IDLE),
      .found   (found),
      .gsel    (gsel),
      .rsp_vld (rsp_valid[i]),
      .rsp_rdy (rsp_ready[i]),
      .req_rdy (req_ready[i]),
      .rsp_hs  (rsp_hs[i])
    );
  end

  // rsp_valid is only ever set for grant_id, so other rsp_ready bits drop out.
  assign handshake = |rsp_hs;

  // Watchdog fires on the last WAIT cycle; a coincident done takes precedence.
  assign wdog    = (state == S_WAIT) && !div_done && (cnt == CW'(TIMEOUT - 1));
  assign div_rst = rst | wdog;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      grant_id   <= '0;
      cnt        <= '0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_valid  <= '0;
      rsp_val    <= '0;
      rsp_status <= 2'b00;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            div_a     <= a_arr[gsel];
            div_b     <= b_arr[gsel];
            grant_id  <= gsel;
            div_start <= 1'b1;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          div_start <= 1'b0;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            rsp_valid <= NREQ'(1) << grant_id;
            state     <= S_RESP;
            if (div_dbz) begin
              rsp_status <= 2'b01;
              rsp_val    <= '0;
            end else if (div_ovf) begin
              rsp_status <= 2'b10;
              rsp_val    <= '0;
            end else begin
              rsp_status <= 2'b00;
              rsp_val    <= div_val;
            end
          end else if (wdog) begin
            rsp_valid  <= NREQ'(1) << grant_id;
            rsp_status <= 2'b11;
            rsp_val    <= '0;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (handshake) begin
            rsp_valid <= '0;
            ptr       <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divu_arbiter.sv
// Bench for divu_arbiter: behavioural divider stand-in, monitors on accept,
// start and response events, and a round-robin / arithmetic reference model.

module tb_divu_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int FBITS   = 16;
  localparam int TIMEOUT = WIDTH + FBITS + 4;
  localparam int IDW     = 2;
  localparam int LAT     = WIDTH + FBITS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
  logic [WIDTH-1:0]      rsp_val, div_a, div_b;
  logic [1:0]            rsp_status;
  logic [IDW-1:0]        grant_id;
  logic                  busy, div_rst, div_start;
  logic                  div_busy = 1'b0, div_done = 1'b0, div_valid = 1'b0;
  logic                  div_dbz = 1'b0, div_ovf = 1'b0;
  logic [WIDTH-1:0]      div_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_val(rsp_val), .rsp_status(rsp_status), .grant_id(grant_id), .busy(busy),
    .div_rst(div_rst), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_valid(div_valid),
    .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val)
  );

  // ---- divider stand-in: done LAT cycles after start, garbage value on error
  logic                   hang = 1'b0;
  logic                   dact = 1'b0;
  int                     dcnt = 0;
  logic [WIDTH-1:0]       la = '0, lb = '0;
  logic [WIDTH+FBITS-1:0] mq;
  assign mq = (lb == 0) ? '0 : {la, {FBITS{1'b0}}} / {{FBITS{1'b0}}, lb};

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_rst) begin
      dact <= 1'b0; div_busy <= 1'b0;
    end else if (div_start) begin
      dact <= 1'b1; div_busy <= 1'b1; dcnt <= 1; la <= div_a; lb <= div_b;
    end else if (dact) begin
      if (dcnt == LAT - 1 && !hang) begin
        dact      <= 1'b0;
        div_busy  <= 1'b0;
        div_done  <= 1'b1;
        div_dbz   <= (lb == 0);
        div_ovf   <= (lb == 0) ? 1'($urandom_range(0, 1)) : |mq[WIDTH+FBITS-1:WIDTH];
        div_valid <= (lb != 0) && !(|mq[WIDTH+FBITS-1:WIDTH]);
        div_val   <= ((lb != 0) && !(|mq[WIDTH+FBITS-1:WIDTH])) ? mq[WIDTH-1:0] : $urandom;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  // ---- monitors
  typedef struct { int id; int cyc; } acc_t;
  typedef struct { int cyc; logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } st_t;
  typedef struct { logic [NREQ-1:0] rv; logic [WIDTH-1:0] val; logic [1:0] st; int gid; int cyc; } rsp_t;
  acc_t acc_q[$];
  st_t  start_q[$];
  rsp_t rsp_q[$];
  int   cyc = 0, rv_seen = 0, drst_cnt = 0, multi_rdy = 0;

  function automatic int oh2id(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if ($countones(req_ready) > 1) multi_rdy <= multi_rdy + 1;
      if (req_ready != '0) acc_q.push_back('{oh2id(req_ready), cyc});
      if (div_start) start_q.push_back('{cyc, div_a, div_b});
      if (rsp_valid != '0) rv_seen <= rv_seen + 1;
      if ((rsp_valid & rsp_ready) != '0)
        rsp_q.push_back('{rsp_valid, rsp_val, rsp_status, int'(grant_id), cyc});
      if (div_rst) drst_cnt <= drst_cnt + 1;
    end
  end

  // ---- reference model
  int mptr = 0;

  function automatic int pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [1:0] st, output logic [WIDTH-1:0] v);
    longint unsigned q;
    st = 2'b00; v = '0;
    if (b == 0) begin st = 2'b01; return; end
    q = (longint'(a) << FBITS) / longint'(b);
    if (q > 64'h0000_0000_FFFF_FFFF) begin st = 2'b10; return; end
    v = q[WIDTH-1:0];
  endfunction

  // ---- stimulus plumbing (no checking here)
  task automatic wait_acc(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (acc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [NREQ-1:0] mask, output bit ok);
    int n = acc_q.size() + 1;
    @(negedge clk);
    req_valid = mask;
    wait_acc(n, ok);
    req_valid = '0;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // ---- tests
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (div_rst !== 1'b1) begin errors++; $display("FAIL reset_div_rst got=%b exp=1", div_rst); end
    checks++;
    if ({busy, div_start, rsp_valid, rsp_status, grant_id} !== '0 || div_a !== '0 || div_b !== '0 || rsp_val !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b start=%b rv=%b st=%b gid=%0d a=%h b=%h val=%h exp all 0",
               busy, div_start, rsp_valid, rsp_status, grant_id, div_a, div_b, rsp_val);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (div_rst !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL reset_release div_rst=%b req_ready=%b exp 0/0", div_rst, req_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    rsp_ready = '1;
    set_op(1, 32'h0003_0000, 32'h0002_0000);
    issue(4'b0010, ok);
    wait_rsp(rsp_q.size() + 1, ok);
    checks++;
    if (!ok || acc_q[$].id != 1) begin errors++; $display("FAIL basic_grant ok=%0d exp grant 1", ok); end
    checks++;
    if (start_q[$].cyc - acc_q[$].cyc != 1 || start_q[$].a !== 32'h0003_0000 || start_q[$].b !== 32'h0002_0000) begin
      errors++; $display("FAIL basic_start dt=%0d a=%h b=%h exp 1/00030000/00020000",
                         start_q[$].cyc - acc_q[$].cyc, start_q[$].a, start_q[$].b);
    end
    checks++;
    if (rsp_q[$].cyc - acc_q[$].cyc != LAT + 2 || rsp_q[$].rv !== 4'b0010 || rsp_q[$].gid != 1) begin
      errors++; $display("FAIL basic_rsp lat=%0d rv=%b gid=%0d exp %0d/0010/1",
                         rsp_q[$].cyc - acc_q[$].cyc, rsp_q[$].rv, rsp_q[$].gid, LAT + 2);
    end
    checks++;
    if (rsp_q[$].val !== 32'h0001_8000 || rsp_q[$].st !== 2'b00) begin
      errors++; $display("FAIL basic_val val=%h st=%b exp 00018000/00", rsp_q[$].val, rsp_q[$].st);
    end
    mptr = 2;
  endtask

  task automatic test_dbz();
    bit ok;
    int d0 = drst_cnt;
    set_op(0, 32'h1234_0000, 32'h0);
    issue(4'b0001, ok);
    wait_rsp(rsp_q.size() + 1, ok);
    checks++;
    if (!ok || rsp_q[$].st !== 2'b01 || rsp_q[$].val !== '0 || rsp_q[$].rv !== 4'b0001) begin
      errors++; $display("FAIL dbz_rsp ok=%0d st=%b val=%h exp 01/0", ok, rsp_q[$].st, rsp_q[$].val);
    end
    checks++;
    if (drst_cnt != d0) begin errors++; $display("FAIL dbz_no_div_rst pulses=%0d exp 0", drst_cnt - d0); end
    mptr = 1;
  endtask

  task automatic test_ovf();
    bit ok;
    set_op(2, 32'hFFFF_0000, 32'h1);
    issue(4'b0100, ok);
    wait_rsp(rsp_q.size() + 1, ok);
    checks++;
    if (!ok || rsp_q[$].st !== 2'b10 || rsp_q[$].val !== '0 || rsp_q[$].gid != 2) begin
      errors++; $display("FAIL ovf_rsp ok=%0d st=%b val=%h gid=%0d exp 10/0/2",
                         ok, rsp_q[$].st, rsp_q[$].val, rsp_q[$].gid);
    end
    mptr = 3;
  endtask

  task automatic test_timeout();
    bit ok;
    int d0 = drst_cnt;
    hang = 1'b1;
    set_op(2, 32'h0005_0000, 32'h0001_0000);
    issue(4'b0100, ok);
    wait_rsp(rsp_q.size() + 1, ok);
    hang = 1'b0;
    checks++;
    if (!ok || rsp_q[$].st !== 2'b11 || rsp_q[$].val !== '0) begin
      errors++; $display("FAIL timeout_rsp ok=%0d st=%b val=%h exp 11/0", ok, rsp_q[$].st, rsp_q[$].val);
    end
    checks++;
    if (rsp_q[$].cyc - acc_q[$].cyc != TIMEOUT + 2 || drst_cnt - d0 != 1) begin
      errors++; $display("FAIL timeout_timing lat=%0d pulses=%0d exp %0d/1",
                         rsp_q[$].cyc - acc_q[$].cyc, drst_cnt - d0, TIMEOUT + 2);
    end
    mptr = 3;
    set_op(1, 32'h0003_0000, 32'h0002_0000);
    issue(4'b0010, ok);
    wait_rsp(rsp_q.size() + 1, ok);
    checks++;
    if (!ok || rsp_q[$].st !== 2'b00 || rsp_q[$].val !== 32'h0001_8000 || rsp_q[$].cyc - acc_q[$].cyc != LAT + 2) begin
      errors++; $display("FAIL timeout_recover st=%b val=%h lat=%0d exp 00/00018000/%0d",
                         rsp_q[$].st, rsp_q[$].val, rsp_q[$].cyc - acc_q[$].cyc, LAT + 2);
    end
    mptr = 2;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0, r0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    mptr = 0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'((i + 1) << 16), 32'h0000_4000);
    rsp_ready = '1;
    n0 = acc_q.size(); r0 = rsp_q.size();
    req_valid = '1;
    wait_acc(n0 + 5, ok);
    req_valid = '0;
    wait_rsp(r0 + 5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_progress accepts=%0d rsps=%0d exp 5/5", acc_q.size() - n0, rsp_q.size() - r0); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acc_q[n0+k].id != pick(mptr, 4'b1111) || rsp_q[r0+k].gid != acc_q[n0+k].id ||
            (k > 0 && acc_q[n0+k].cyc - acc_q[n0+k-1].cyc != LAT + 3)) begin
          errors++; $display("FAIL rr_order k=%0d id=%0d gid=%0d exp %0d interval exp %0d",
                             k, acc_q[n0+k].id, rsp_q[r0+k].gid, pick(mptr, 4'b1111), LAT + 3);
        end
        mptr = (acc_q[n0+k].id + 1) % NREQ;
      end
    end
  endtask

  task automatic test_hold();
    bit ok;
    logic [1:0] est;
    logic [WIDTH-1:0] ev;
    rsp_ready = 4'b0111;
    set_op(3, 32'h0007_8000, 32'h0000_3000);
    ref_div(32'h0007_8000, 32'h0000_3000, est, ev);
    issue(4'b1000, ok);
    req_valid = 4'b0001;
    for (int k = 0; k < 200 && rsp_valid == '0; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_val !== ev || rsp_status !== est || req_ready !== '0) begin
        errors++; $display("FAIL hold_stable k=%0d rv=%b val=%h st=%b rr=%b exp 1000/%h/%b/0000",
                           k, rsp_valid, rsp_val, rsp_status, req_ready, ev, est);
      end
      @(negedge clk);
    end
    rsp_ready = '1;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(rsp_q.size(), ok);
    checks++;
    if (rsp_q[$].gid != 3 || rsp_q[$].val !== ev) begin
      errors++; $display("FAIL hold_release gid=%0d val=%h exp 3/%h", rsp_q[$].gid, rsp_q[$].val, ev);
    end
    mptr = 0;
  endtask

  task automatic test_random();
    bit ok;
    logic [NREQ-1:0] mask;
    logic [1:0] est;
    logic [WIDTH-1:0] ev, ea, eb;
    int g, hold, r0;
    for (int it = 0; it < 10; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 3))
          0:       set_op(i, $urandom, 32'h0);
          1:       set_op(i, $urandom, 32'($urandom_range(1, 3)));
          default: set_op(i, $urandom, $urandom);
        endcase
      end
      g = pick(mptr, mask);
      ea = req_a[g*WIDTH +: WIDTH];
      eb = req_b[g*WIDTH +: WIDTH];
      ref_div(ea, eb, est, ev);
      hold = $urandom_range(0, 3);
      rsp_ready = (hold == 0) ? '1 : '0;
      r0 = rsp_q.size();
      issue(mask, ok);
      if (hold > 0) begin
        repeat (LAT + 1 + hold) @(negedge clk);
        rsp_ready = '1;
      end
      wait_rsp(r0 + 1, ok);
      checks++;
      if (!ok || acc_q[$].id != g || start_q[$].a !== ea || start_q[$].b !== eb) begin
        errors++; $display("FAIL rand_grant it=%0d ok=%0d id=%0d a=%h b=%h exp %0d/%h/%h",
                           it, ok, acc_q[$].id, start_q[$].a, start_q[$].b, g, ea, eb);
      end
      checks++;
      if (rsp_q[$].rv !== NREQ'(1 << g) || rsp_q[$].st !== est || rsp_q[$].val !== ev ||
          (hold == 0 && rsp_q[$].cyc - acc_q[$].cyc != LAT + 2)) begin
        errors++; $display("FAIL rand_rsp it=%0d rv=%b st=%b val=%h lat=%0d exp g=%0d st=%b val=%h",
                           it, rsp_q[$].rv, rsp_q[$].st, rsp_q[$].val, rsp_q[$].cyc - acc_q[$].cyc, g, est, ev);
      end
      mptr = (g + 1) % NREQ;
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int rv0, rq0;
    rsp_ready = '1;
    set_op(0, 32'h0003_0000, 32'h0002_0000);
    issue(4'b0001, ok);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, div_start, rsp_valid, rsp_status, grant_id} !== '0 || div_a !== '0 || div_b !== '0 ||
        rsp_val !== '0 || div_rst !== 1'b1) begin
      errors++; $display("FAIL midwait_reset busy=%b start=%b rv=%b a=%h div_rst=%b exp reset values",
                         busy, div_start, rsp_valid, div_a, div_rst);
    end
    rst = 1'b0;
    rv0 = rv_seen; rq0 = rsp_q.size();
    repeat (LAT + 10) @(negedge clk);
    checks++;
    if (rv_seen != rv0 || rsp_q.size() != rq0 || busy !== 1'b0) begin
      errors++; $display("FAIL midwait_no_rsp rv_cycles=%0d busy=%b exp 0/0", rv_seen - rv0, busy);
    end
    mptr = 0;
  endtask

  task automatic test_invariants();
    checks++;
    if (multi_rdy != 0) begin errors++; $display("FAIL req_ready_onehot violations=%0d exp 0", multi_rdy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_ovf();
    test_timeout();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_mid_wait();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_time_limit checks=%0d", checks);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/divu_arbiter.md
# divu_arbiter

- Shares one `divu` fixed-point divider among `NREQ` requesters.
- Accepts one division at a time using round-robin arbitration and launches it on the divider.
- Returns the quotient with a 2-bit status to the granted requester over a valid/ready response channel.
- Includes a watchdog: if the divider never reports `done`, it resets the divider and returns a timeout status.

## Interface
- Reset and clock: reset `rst`, synchronous, active-high; clock `clk`.

Parameters:
- `NREQ`, 4: number of requesters (≥1).
- `WIDTH`, 32: operand/result width; must match divider `WIDTH`.
- `FBITS`, 16: fractional bits; must match divider `FBITS`.
- `TIMEOUT`, `WIDTH+FBITS+4`: cycles in WAIT before declaring timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester accept; at most one bit high.
- `req_a` in `NREQ*WIDTH`: dividends; requester i at `[i*WIDTH +: WIDTH]`.
- `req_b` in `NREQ*WIDTH`: divisors; same packing.
- `rsp_valid` out `NREQ`: one-hot response valid.
- `rsp_ready` in `NREQ`: per-requester response accept.
- `rsp_val` out `WIDTH`: quotient; 0 unless status is 00.
- `rsp_status` out 2: 00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.
- `grant_id` out `$clog2(NREQ)` (min 1): index of the current/last granted requester.
- `busy` out 1: high in every state except IDLE.
- `div_rst` out 1, `div_start` out 1, `div_a` out `WIDTH`, `div_b` out `WIDTH`: to the divider.
- `div_busy`, `div_done`, `div_valid`, `div_dbz`, `div_ovf` in 1; `div_val` in `WIDTH`: from the divider.

## Operation
State machine: IDLE, START, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is high, select g as the first set bit at or after `ptr`, wrapping modulo `NREQ`.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - Register `req_a[g]` into `div_a`, `req_b[g]` into `div_b`, and g into `grant_id`, then go to START.
  - `req_ready` is 0 in all other states. A requester may drop `req_valid` before being granted.
- **START**
  - `div_start=1` for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
  - `div_a`/`div_b` stay stable from START until the return to IDLE.
- **WAIT**
  - The counter increments every cycle.
  - On `div_done`, capture the status with priority `div_dbz` → 01, then `div_ovf` → 10, then `div_valid` → 00.
  - Set `rsp_val=div_val` only when status is 00; otherwise set it to 0. Go to RESP.
  - If the counter reaches `TIMEOUT-1` without `div_done`: status 11, `rsp_val=0`, `div_rst=1` for that one cycle, go to RESP.
- **RESP**
  - `rsp_valid[grant_id]=1`; `rsp_val` and `rsp_status` are held stable until `rsp_ready[grant_id]`.
  - On the handshake: `ptr <= (grant_id+1) mod NREQ`, go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- `div_done` outside WAIT is ignored.
- `div_busy` is informational only; the FSM does not use it.
- `div_rst = rst | watchdog_pulse`.

Reset values:
- State IDLE, `ptr=0`, `grant_id=0`, counter 0.
- `div_start=0`, `div_a=0`, `div_b=0`, `rsp_valid=0`, `rsp_val=0`, `rsp_status=00`, `busy=0`.
- `div_rst=1` while `rst` is high.
- Reset in any state, including mid-WAIT, aborts the operation: no response is issued and the request is lost.

## Timing
- Accept in cycle T (IDLE, `req_ready` high) → `div_start` in T+1.
- Divider `done` arrives in T+1+`WIDTH+FBITS` → `rsp_valid` in T+2+`WIDTH+FBITS`.
- `rsp_ready` already high gives a single-cycle RESP; back in IDLE at T+3+`WIDTH+FBITS`. Minimum issue interval is `WIDTH+FBITS+3` cycles.
- A timeout gives `rsp_valid` at T+2+`TIMEOUT`.
- `req_ready` combinational from state/`ptr`/`req_valid`; all other outputs registered.
- `ptr` wraps from `NREQ-1` to 0.
- With `NREQ=1`, the grant is always 0.

## Test plan
- Requester 1 sends a=0x00030000, b=0x00020000 → `div_start` the next cycle; `rsp_valid`=0b0010 after 50 cycles; `rsp_val`=0x00018000, status 00.
- Requester 0 sends b=0 → status 01, `rsp_val`=0, no `div_rst` pulse.
- a=0xFFFF0000, b=0x00000001 → status 10, `rsp_val`=0.
- All four `req_valid` high continuously with `rsp_ready` tied high → grant order 0,1,2,3,0, issue interval 51 cycles.
- Divider model never asserts `done` → after `TIMEOUT`=52 WAIT cycles, one-cycle `div_rst`; status 11, `rsp_val`=0; the next request completes normally.
- Hold `rsp_ready` low 10 cycles → `rsp_val`/`rsp_status` stable and `req_ready` all 0. Separately, assert `rst` mid-WAIT → IDLE next cycle, no `rsp_valid`, all outputs at reset values.
